// File: rtl/pulse_responder.sv
// Pulse propagation responder: answers each accepted rising edge on recieved_signal with a
// fixed-turnaround reply pulse. Build option PULSE_RESPONDER_SYNC_EN adds a two-flop input synchronizer.
//
// state | meaning
// IDLE  | waiting for an enabled rising edge
// TURN  | counting the turnaround before the reply
// REPLY | driving sent_signal high
// HOLD  | dead time after the reply, edges are flagged as missed
module pulse_responder #(
  parameter int PERIODS_DIM = 16,
  parameter int TURNAROUND  = 260,
  parameter int PULSE_WIDTH = 130,
  parameter int HOLDOFF     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   recieved_signal,
  input  logic                   enable,
  input  logic                   clear_stats,
  output logic                   sent_signal,
  output logic                   busy,
  output logic [PERIODS_DIM-1:0] reply_count,
  output logic                   missed
);

  localparam logic [PERIODS_DIM-1:0] TURN_LOAD  = PERIODS_DIM'(TURNAROUND - 1);
  localparam logic [PERIODS_DIM-1:0] PULSE_LOAD = PERIODS_DIM'(PULSE_WIDTH - 1);
  localparam logic [PERIODS_DIM-1:0] HOLD_LOAD  = PERIODS_DIM'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {IDLE, TURN, REPLY, HOLD} state_t;

  state_t                 state;
  logic [PERIODS_DIM-1:0] cnt;
  logic                   in_s;
  logic                   in_d;
  logic                   rx_edge;

`ifdef PULSE_RESPONDER_SYNC_EN
  logic sync_1;
  logic sync_2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      in_s   <= 1'b0;
    end else begin
      sync_1 <= recieved_signal;
      sync_2 <= sync_1;
      in_s   <= sync_2;
    end
  end
`else
  // Input already synchronous to clk; no metastability protection here.
  always_ff @(posedge clk) begin
    if (rst) in_s <= 1'b0;
    else     in_s <= recieved_signal;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) in_d <= 1'b0;
    else     in_d <= in_s;
  end

  assign rx_edge = in_s & ~in_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sent_signal <= 1'b0;
      busy        <= 1'b0;
      reply_count <= '0;
      missed      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_edge && enable) begin
            state <= TURN;
            cnt   <= TURN_LOAD;
            busy  <= 1'b1;
          end
        end
        TURN: begin
          if (cnt == '0) begin
            state       <= REPLY;
            cnt         <= PULSE_LOAD;
            sent_signal <= 1'b1;
            reply_count <= reply_count + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        REPLY: begin
          if (cnt == '0) begin
            sent_signal <= 1'b0;
            if (HOLDOFF == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= HOLD;
              cnt   <= HOLD_LOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          sent_signal <= 1'b0;
          busy        <= 1'b0;
        end
      endcase

      if (rx_edge && (state != IDLE)) missed <= 1'b1;

      // Clearing wins over a same-cycle count increment or missed-edge set.
      if (clear_stats) begin
        reply_count <= '0;
        missed      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_responder.sv
// Scoreboard bench for pulse_responder: stimulus pushes expected replies, a monitor checks
// reply timing, width, count and busy release; a second small instance checks counter wrap.
`timescale 1ps/1ps
module tb_pulse_responder;

`ifdef PULSE_RESPONDER_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif
  localparam int TA = 260;
  localparam int PW = 130;
  localparam int HO = 64;

  typedef struct {
    int rise;
    int width;
    int count;
    int busy_fall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        enable;
  logic        clear_stats;
  logic        sent_signal;
  logic        busy;
  logic [15:0] reply_count;
  logic        missed;

  logic        w_rx;
  logic        w_sent;
  logic        w_busy;
  logic [3:0]  w_count;
  logic        w_missed;

  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  exp_t exp_q[$];

  pulse_responder dut (
    .clk(clk), .rst(rst), .recieved_signal(rx), .enable(enable), .clear_stats(clear_stats),
    .sent_signal(sent_signal), .busy(busy), .reply_count(reply_count), .missed(missed)
  );

  pulse_responder #(.PERIODS_DIM(4), .TURNAROUND(3), .PULSE_WIDTH(2), .HOLDOFF(0)) dut_wrap (
    .clk(clk), .rst(rst), .recieved_signal(w_rx), .enable(1'b1), .clear_stats(1'b0),
    .sent_signal(w_sent), .busy(w_busy), .reply_count(w_count), .missed(w_missed)
  );

  always #385 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    nvec++;
    if (actual != expected) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Drive one input pulse; when a reply is expected, queue its timing and count.
  task automatic fire(input int hi, input bit expect_reply, input int cnt, input int wid,
                      input int hold, output int rise);
    exp_t e;
    @(negedge clk);
    rise = cyc + 1 + 1 + L + TA;
    if (expect_reply) begin
      e.rise      = rise;
      e.width     = wid;
      e.count     = cnt;
      e.busy_fall = rise + wid + hold;
      exp_q.push_back(e);
    end
    rx = 1'b1;
    repeat (hi) @(negedge clk);
    rx = 1'b0;
  endtask

  initial begin : monitor
    bit   sp = 1'b0;
    bit   bp = 1'b0;
    bit   act = 1'b0;
    int   w = 0;
    exp_t cur;
    forever begin
      @(negedge clk);
      if (sent_signal && !sp) begin
        w = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_reply", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          act = 1'b1;
          check("reply_rise_cycle", cyc, cur.rise);
          check("reply_count_at_rise", int'(reply_count), cur.count);
        end
      end
      if (sent_signal) w++;
      if (!sent_signal && sp && act) check("reply_width", w, cur.width);
      if (!busy && bp && act) begin
        check("busy_fall_cycle", cyc, cur.busy_fall);
        act = 1'b0;
      end
      sp = sent_signal;
      bp = busy;
    end
  end

  initial begin : stimulus
    int r;
    rst = 1'b1; rx = 1'b0; enable = 1'b0; clear_stats = 1'b0; w_rx = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_sent", sent_signal, 0);
    check("reset_busy", busy, 0);
    check("reset_count", int'(reply_count), 0);
    check("reset_missed", missed, 0);

    // Disabled: edge ignored entirely.
    fire(130, 1'b0, 0, 0, 0, r);
    check("disabled_busy", busy, 0);
    wait_until(cyc + 300);
    check("disabled_count", int'(reply_count), 0);
    check("disabled_missed", missed, 0);

    // Single pulse.
    enable = 1'b1;
    fire(130, 1'b1, 1, PW, HO, r);
    wait_until(r + 5);
    check("single_busy_during", busy, 1);
    wait_until(r + PW + HO + 5);
    check("single_count", int'(reply_count), 1);
    check("single_missed", missed, 0);
    check("single_busy_after", busy, 0);

    // Pulse while busy, after clearing the statistics.
    @(negedge clk); clear_stats = 1'b1;
    @(negedge clk); clear_stats = 1'b0;
    check("clear_count", int'(reply_count), 0);
    fire(50, 1'b1, 1, PW, HO, r);
    repeat (50) @(negedge clk);
    rx = 1'b1;
    repeat (50) @(negedge clk);
    rx = 1'b0;
    wait_until(r + PW + HO + 5);
    check("busy_edge_missed", missed, 1);
    check("busy_edge_count", int'(reply_count), 1);
    fire(50, 1'b1, 2, PW, HO, r);
    wait_until(r + PW + HO + 5);
    check("third_pulse_count", int'(reply_count), 2);

    // Reset 50 cycles into REPLY, then a normal reply.
    fire(20, 1'b1, 3, 50, 0, r);
    wait_until(r + 49);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_sent", sent_signal, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_count", int'(reply_count), 0);
    check("rst_mid_missed", missed, 0);
    fire(20, 1'b1, 1, PW, HO, r);
    wait_until(r + PW + HO + 5);
    check("post_rst_count", int'(reply_count), 1);

    // clear_stats on the TURN->REPLY edge drops that increment.
    fire(20, 1'b1, 0, PW, HO, r);
    wait_until(r - 1);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    wait_until(r + PW + HO + 5);
    check("clear_collision_count", int'(reply_count), 0);

    // Wrap on the 4-bit instance.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); w_rx = 1'b1;
      repeat (2) @(negedge clk); w_rx = 1'b0;
      repeat (14) @(negedge clk);
      check($sformatf("wrap_count_%0d", i + 1), int'(w_count), (i + 1) % 16);
    end
    check("wrap_missed", w_missed, 0);

    check("pending_replies", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pulse_responder.md
# pulse_responder

Remote end of the pulse propagation measurement. Detects a rising edge on the incoming pulse, waits a fixed turnaround of `TURNAROUND` clock periods, then emits a reply pulse of `PULSE_WIDTH` periods. The measuring side times this reply; its measured delay equals round-trip propagation plus the known turnaround. The block sits on the wireless receiver board between the RF detector input and the transmitter drive.

## Interface
- `PERIODS_DIM`, 16: width of the internal counters and of `reply_count`.
- `TURNAROUND`, 260: clk periods from edge detection to reply rise. Range 1 to 2^PERIODS_DIM-1.
- `PULSE_WIDTH`, 130: reply high time in clk periods. Range 1 to 2^PERIODS_DIM-1.
- `HOLDOFF`, 64: dead time after the reply, in clk periods. Range 0 to 2^PERIODS_DIM-1.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `recieved_signal` input 1: incoming pulse, asynchronous to `clk`.
- `enable` input 1: arms the responder. It is sampled only in IDLE.
- `clear_stats` input 1: synchronous clear of `reply_count` and `missed`.
- `sent_signal` output 1: reply pulse, registered.
- `busy` output 1: high whenever the state is not IDLE.
- `reply_count` output PERIODS_DIM: number of replies issued. Wraps modulo 2^PERIODS_DIM.
- `missed` output 1: sticky flag. Set when a rising edge is detected while not in IDLE.

## Operation
- **Edge detect.** Input path (see Configuration) feeds `in_s`. A register `in_d` holds the previous `in_s`. `edge = in_s & ~in_d`. A level held high never retriggers.
- **FSM states:** IDLE, TURN, REPLY, HOLD. There is one down-counter `cnt` of PERIODS_DIM bits.
  - IDLE: if `edge & enable`, load `cnt = TURNAROUND-1` and go to TURN. If `edge & ~enable`, ignore the edge; `missed` is not set.
  - TURN: decrement `cnt`. At `cnt==0`, load `PULSE_WIDTH-1`, go to REPLY, and increment `reply_count`.
  - REPLY: `sent_signal=1`. Decrement `cnt`. At `cnt==0`: if `HOLDOFF==0`, go to IDLE; otherwise load `HOLDOFF-1` and go to HOLD.
  - HOLD: decrement `cnt`. At `cnt==0`, go to IDLE.
- **Missed edges.** An `edge` in TURN, REPLY or HOLD sets `missed`. The sequence in progress is unaffected.
- **`enable` deasserted mid-sequence.** The sequence completes normally. Only the next IDLE edge is gated.
- **`sent_signal` register.** It is a register output, high exactly in the cycles when the state is REPLY. There is no combinational path from any input.
- **`clear_stats`.** Zeroes `reply_count` and `missed` on the next edge. It has priority over a same-cycle increment or `missed` set; that event is dropped.
- **Reset.** `rst` has priority over everything, including mid-operation. Next edge:
  - state=IDLE, `cnt=0`;
  - `sent_signal=0`, `busy=0`, `reply_count=0`, `missed=0`;
  - synchronizer and `in_d` registers = 0.

## Timing
- Let edge E0 be the first `clk` edge that samples `recieved_signal`=1 after it was 0.
- Detection latency L is 2 with the synchronizer and 0 without. The FSM enters TURN at edge E0+1+L.
- `sent_signal` rises at E0+1+L+TURNAROUND. It stays high for exactly PULSE_WIDTH cycles.
- `busy` rises with the TURN entry. It falls at E0+1+L+TURNAROUND+PULSE_WIDTH+HOLDOFF.
- Minimum re-trigger spacing: a new edge is accepted only if it is detected at or after the cycle `busy` is low.
- `reply_count` updates on the same edge where `sent_signal` rises.
- Input pulses narrower than one clk period may be missed. Minimum guaranteed input high time is one clk period plus setup/hold.

## Configuration
- `PULSE_RESPONDER_SYNC_EN` defined: `recieved_signal` passes through a two-flop synchronizer before `in_s`, so L=2. This is the default for board builds.
- `PULSE_RESPONDER_SYNC_EN` undefined: `in_s` is a single register on `recieved_signal`, so L=0. This is for simulation-only latency checks and for inputs already synchronous to `clk`. Metastability protection is absent.

## Test plan
All scenarios use the defaults, `PULSE_RESPONDER_SYNC_EN` defined, and a 770 ps clk.
- **Single pulse.** `enable`=1, 130-cycle input pulse. `sent_signal` rises exactly 263 cycles after E0, stays high 130 cycles, then `reply_count`=1. `busy` falls 194 cycles after the rise.
- **Disabled.** `enable`=0, input pulse. `sent_signal` stays 0, `busy`=0, `reply_count`=0, `missed`=0.
- **Pulse while busy.** Second input edge 100 cycles after the first. One reply only, `missed`=1, `reply_count`=1. A third pulse after `busy` falls gives `reply_count`=2.
- **Reset mid-reply.** `rst` asserted 50 cycles into REPLY. On the next edge `sent_signal`=0, `busy`=0, `reply_count`=0. A subsequent pulse gives a normal reply.
- **Clear collision.** `clear_stats` asserted on the same cycle as the TURN to REPLY transition. `reply_count`=0 afterward, and `sent_signal` still pulses 130 cycles.
- **Wrap.** PERIODS_DIM=4, TURNAROUND=3, PULSE_WIDTH=2, HOLDOFF=0, 17 spaced pulses. `reply_count` reads 0 after the 16th reply and 1 after the 17th.
